// File: rtl/ldm_stm_transfer_sequencer.sv
// Purpose: steps an LDM/STM block transfer through memory, then optionally writes back the base register.
// Latency: first access 1 cycle after start; one cycle per word plus waits; then WB (if W) and a DONE cycle.
// Backpressure: mem_ready_in low freezes every output and all state until the memory accepts the access.
module ldm_stm_transfer_sequencer (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic [15:0] reg_list_in,
  input  logic [31:0] base_in,
  input  logic        p_bit_in,
  input  logic        u_bit_in,
  input  logic        w_bit_in,
  input  logic        l_bit_in,
  input  logic [3:0]  reg_addr_in,
  input  logic        reg_last_in,
  input  logic        mem_ready_in,
  output logic        gen_start_out,
  output logic        reg_next_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  rf_addr_out,
  output logic        rf_we_out,
  output logic        wb_en_out,
  output logic [31:0] wb_data_out,
  output logic        busy_out,
  output logic        done_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wb_val_q;
  logic        load_q;
  logic        wb_q;

  logic [4:0]  n_regs;
  logic [31:0] n_bytes;
  logic [31:0] start_addr;
  logic [31:0] wb_val;
  logic        in_xfer;
  logic        xfer_fire;

  // Count the registers in the list; 0..16 needs five bits.
  always_comb begin
    n_regs = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n_regs = n_regs + {4'd0, reg_list_in[i]};
    end
  end

  assign n_bytes = {25'd0, n_regs, 2'b00};

  // Lowest address of the block; registers always go out in ascending order from here.
  always_comb begin
    start_addr = base_in;
    case ({p_bit_in, u_bit_in})
      2'b01:   start_addr = base_in;                          // IA
      2'b11:   start_addr = base_in + 32'd4;                  // IB
      2'b00:   start_addr = base_in - n_bytes + 32'd4;        // DA
      default: start_addr = base_in - n_bytes;                // DB
    endcase
  end

  assign wb_val = u_bit_in ? (base_in + n_bytes) : (base_in - n_bytes);

  assign in_xfer   = (state_q == XFER);
  // Reset in the same cycle suppresses the handshake strobes.
  assign xfer_fire = in_xfer & mem_ready_in & ~reset_in;

  // Sequencer state and the fields captured at launch.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      wb_val_q <= 32'd0;
      load_q   <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            load_q   <= l_bit_in;
            wb_q     <= w_bit_in;
            wb_val_q <= wb_val;
            addr_q   <= start_addr;
            // An empty list skips both the accesses and the writeback.
            state_q  <= (n_regs == 5'd0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (mem_ready_in) begin
            addr_q <= addr_q + 32'd4;
            if (reg_last_in) begin
              state_q <= wb_q ? WB : DONE;
            end
          end
        end
        WB: begin
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gen_start_out = start_in & (state_q == IDLE) & ~reset_in;
  assign busy_out      = (state_q != IDLE);
  assign done_out      = (state_q == DONE);

  assign mem_req_out   = in_xfer;
  assign mem_we_out    = in_xfer & ~load_q;
  assign mem_addr_out  = in_xfer ? addr_q : 32'd0;
  assign rf_addr_out   = in_xfer ? reg_addr_in : 4'd0;
  assign rf_we_out     = xfer_fire & load_q;
  assign reg_next_out  = xfer_fire & ~reg_last_in;

  assign wb_en_out     = (state_q == WB);
  assign wb_data_out   = (state_q == WB) ? wb_val_q : 32'd0;

endmodule

// File: tb/tb_ldm_stm_transfer_sequencer.sv
module tb_ldm_stm_transfer_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic [15:0] reg_list_in;
  logic [31:0] base_in;
  logic        p_bit_in, u_bit_in, w_bit_in, l_bit_in;
  logic [3:0]  reg_addr_in;
  logic        reg_last_in;
  logic        mem_ready_in;
  logic        gen_start_out, reg_next_out, mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out;
  logic [3:0]  rf_addr_out;
  logic        rf_we_out, wb_en_out;
  logic [31:0] wb_data_out;
  logic        busy_out, done_out;

  int vectors     = 0;
  int miscompares = 0;

  ldm_stm_transfer_sequencer dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .start_in      (start_in),
    .reg_list_in   (reg_list_in),
    .base_in       (base_in),
    .p_bit_in      (p_bit_in),
    .u_bit_in      (u_bit_in),
    .w_bit_in      (w_bit_in),
    .l_bit_in      (l_bit_in),
    .reg_addr_in   (reg_addr_in),
    .reg_last_in   (reg_last_in),
    .mem_ready_in  (mem_ready_in),
    .gen_start_out (gen_start_out),
    .reg_next_out  (reg_next_out),
    .mem_req_out   (mem_req_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .rf_addr_out   (rf_addr_out),
    .rf_we_out     (rf_we_out),
    .wb_en_out     (wb_en_out),
    .wb_data_out   (wb_data_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".gen_start"}, gen_start_out, 0);
    chk({tag, ".reg_next"},  reg_next_out,  0);
    chk({tag, ".mem_req"},   mem_req_out,   0);
    chk({tag, ".mem_we"},    mem_we_out,    0);
    chk({tag, ".mem_addr"},  mem_addr_out,  0);
    chk({tag, ".rf_addr"},   rf_addr_out,   0);
    chk({tag, ".rf_we"},     rf_we_out,     0);
    chk({tag, ".wb_en"},     wb_en_out,     0);
    chk({tag, ".wb_data"},   wb_data_out,   0);
    chk({tag, ".busy"},      busy_out,      0);
    chk({tag, ".done"},      done_out,      0);
  endtask

  // Scramble the launch fields so any late sampling of them shows up.
  task automatic scramble_fields();
    reg_list_in = 16'($urandom);
    base_in     = $urandom;
    {p_bit_in, u_bit_in, w_bit_in, l_bit_in} = 4'($urandom);
  endtask

  // One whole instruction. The bench plays the register generator and the memory.
  // Expected addresses come from the ARM block-transfer rules: the block spans
  // n words, its lowest word is derived from base/P/U, and registers map upward.
  task automatic run(input string tag, input logic [15:0] list, input logic [31:0] base,
                     input logic p, input logic u, input logic w, input logic l,
                     input int wait_k, input int wait_len, input bit poke);
    int          regs[$];
    int          n;
    int          waits;
    logic [31:0] lowest, wbv, nb;
    for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
    n  = regs.size();
    nb = 32'(4 * n);
    if (u) lowest = p ? base + 32'd4 : base;
    else   lowest = p ? base - nb : base - nb + 32'd4;
    wbv = u ? base + nb : base - nb;

    start_in = 1'b1; reg_list_in = list; base_in = base;
    p_bit_in = p; u_bit_in = u; w_bit_in = w; l_bit_in = l;
    @(negedge clk_in);
    chk({tag, ".c0.gen_start"}, gen_start_out, 1);
    chk({tag, ".c0.busy"}, busy_out, 0);
    next_cycle();
    start_in = 1'b0;
    scramble_fields();

    for (int k = 0; k < n; k++) begin
      reg_addr_in = 4'(regs[k]);
      reg_last_in = (k == n - 1);
      waits = (k == wait_k) ? wait_len : 0;
      for (int j = 0; j <= waits; j++) begin
        mem_ready_in = (j == waits);
        start_in     = poke && (k == 0) && (j == 0);
        @(negedge clk_in);
        chk($sformatf("%s.x%0d.mem_req", tag, k), mem_req_out, 1);
        chk($sformatf("%s.x%0d.mem_we", tag, k), mem_we_out, !l);
        chk($sformatf("%s.x%0d.addr", tag, k), mem_addr_out, lowest + 32'(4 * k));
        chk($sformatf("%s.x%0d.rf_addr", tag, k), rf_addr_out, regs[k]);
        chk($sformatf("%s.x%0d.rf_we", tag, k), rf_we_out, mem_ready_in && l);
        chk($sformatf("%s.x%0d.reg_next", tag, k), reg_next_out, mem_ready_in && (k != n - 1));
        chk($sformatf("%s.x%0d.wb_en", tag, k), wb_en_out, 0);
        chk($sformatf("%s.x%0d.done", tag, k), done_out, 0);
        if (start_in) chk({tag, ".poke.gen_start"}, gen_start_out, 0);
        next_cycle();
        start_in = 1'b0;
      end
    end
    mem_ready_in = 1'b0; reg_addr_in = 4'd0; reg_last_in = 1'b0;

    if (n > 0 && w) begin
      @(negedge clk_in);
      chk({tag, ".wb.en"}, wb_en_out, 1);
      chk({tag, ".wb.data"}, wb_data_out, wbv);
      chk({tag, ".wb.mem_req"}, mem_req_out, 0);
      chk({tag, ".wb.done"}, done_out, 0);
      next_cycle();
    end

    @(negedge clk_in);
    chk({tag, ".done"}, done_out, 1);
    chk({tag, ".done.busy"}, busy_out, 1);
    chk({tag, ".done.mem_req"}, mem_req_out, 0);
    chk({tag, ".done.wb_en"}, wb_en_out, 0);
    next_cycle();
    @(negedge clk_in);
    chk_quiet({tag, ".after"});
    next_cycle();
  endtask

  initial begin
    reset_in = 1'b1; start_in = 1'b0; reg_list_in = 16'd0; base_in = 32'd0;
    p_bit_in = 1'b0; u_bit_in = 1'b0; w_bit_in = 1'b0; l_bit_in = 1'b0;
    reg_addr_in = 4'd0; reg_last_in = 1'b0; mem_ready_in = 1'b0;
    next_cycle();
    next_cycle();
    reset_in = 1'b0;
    @(negedge clk_in);
    chk_quiet("reset");
    next_cycle();

    // Directed cases.
    run("ldmia",   16'h0005, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0);
    run("stmdb",   16'h8003, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
    run("ldmib",   16'h00F0, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0);
    run("ldmda",   16'h00F0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
    run("stall",   16'h000F, 32'h0000_2000, 1'b0, 1'b1, 1'b1, 1'b1,  1, 3, 1'b0);
    run("empty",   16'h0000, 32'h0000_3000, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0);
    run("poke",    16'h0030, 32'h0000_4000, 1'b0, 1'b1, 1'b0, 1'b0,  0, 2, 1'b1);
    run("wrap",    16'h0003, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);

    // Reset in the middle of a transfer, coinciding with a ready memory.
    start_in = 1'b1; reg_list_in = 16'h00FF; base_in = 32'h0000_5000;
    p_bit_in = 1'b0; u_bit_in = 1'b1; w_bit_in = 1'b1; l_bit_in = 1'b1;
    next_cycle();
    start_in = 1'b0; reg_addr_in = 4'd0; reg_last_in = 1'b0; mem_ready_in = 1'b0;
    @(negedge clk_in);
    chk("rst.pre.mem_req", mem_req_out, 1);
    next_cycle();
    reset_in = 1'b1; mem_ready_in = 1'b1;
    @(negedge clk_in);
    chk("rst.same.rf_we", rf_we_out, 0);
    chk("rst.same.reg_next", reg_next_out, 0);
    next_cycle();
    reset_in = 1'b0; mem_ready_in = 1'b0;
    @(negedge clk_in);
    chk_quiet("rst.post");
    next_cycle();

    // Randomized instructions, lists, bases and stall patterns.
    for (int t = 0; t < 24; t++) begin
      logic [15:0] lst;
      logic [3:0]  bits;
      lst  = 16'($urandom);
      if (t % 6 == 5) lst = 16'(1 << $urandom_range(0, 15));
      bits = 4'($urandom);
      run($sformatf("rnd%0d", t), lst, $urandom, bits[3], bits[2], bits[1], bits[0],
          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ldm_stm_transfer_sequencer.md
# ldm_stm_transfer_sequencer

Downstream consumer of the LDM/STM register address generator. Takes a block-transfer instruction's decoded fields, steps through the register numbers the generator supplies, and for each one issues a word memory access at the correct ARM block address (IA/IB/DA/DB). It drives the register-file port for loads, and optionally performs base-register writeback before signalling completion.

## Interface
Parameters: none. Fixed word size 4 bytes, 32-bit addresses.
- clk_in  input  1  single clock; all state updates on rising edge
- reset_in  input  1  synchronous, active-high reset
- start_in  input  1  one-cycle pulse: launch transfer; sampled only in IDLE
- reg_list_in  input  16  register list; bit i = Ri; sampled with start_in
- base_in  input  32  base register value; sampled with start_in
- p_bit_in, u_bit_in, w_bit_in, l_bit_in  input  1 each  pre-index, up, writeback, load(1)/store(0); sampled with start_in
- reg_addr_in  input  4  current register number from generator; valid whenever busy_out=1
- reg_last_in  input  1  generator stop flag: reg_addr_in is the final register
- mem_ready_in  input  1  memory accepts/completes current access this cycle
- gen_start_out  output  1  = start_in & (state==IDLE); drives generator ldm_stm_start_in
- reg_next_out  output  1  advance generator to next register
- mem_req_out  output  1  memory access request
- mem_we_out  output  1  1 = store (STM), 0 = load (LDM)
- mem_addr_out  output  32  word address of current access
- rf_addr_out  output  4  register-file index for current transfer
- rf_we_out  output  1  register-file write strobe (LDM only)
- wb_en_out  output  1  base writeback strobe
- wb_data_out  output  32  new base value
- busy_out  output  1  state != IDLE
- done_out  output  1  one-cycle completion pulse

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE: all outputs 0 except gen_start_out. On start_in, latch fields, n = popcount(reg_list_in) (5 bits, 0..16).
  - n=0: go to DONE. No access, no writeback.
  - n>0: load addr_q and go to XFER.
- Start address, all arithmetic 32-bit modulo 2^32:
  - IA (P=0,U=1): base
  - IB (P=1,U=1): base+4
  - DA (P=0,U=0): base−4n+4
  - DB (P=1,U=0): base−4n
- Writeback value, computed at start: U ? base+4n : base−4n.
- XFER:
  - Outputs: mem_req_out=1, mem_we_out=~L, mem_addr_out=addr_q, rf_addr_out=reg_addr_in.
  - While mem_ready_in=0: hold every output and all internal state.
  - On mem_ready_in=1: rf_we_out=L in the same cycle, then addr_q += 4. Registers are always accessed in ascending number order at ascending addresses.
    - If reg_last_in=0: reg_next_out=1 this cycle; stay in XFER.
    - If reg_last_in=1: reg_next_out=0; go to WB if W=1, otherwise DONE.
- WB: wb_en_out=1, wb_data_out=latched writeback value; go to DONE.
- DONE: done_out=1; go to IDLE.
- start_in outside IDLE is ignored; gen_start_out=0 there.
- R15 and the base register in the list get no special handling; if both apply, a load into the base is overwritten by writeback.
- reset_in=1 in any state: next state IDLE, all registers cleared, no further strobes. Reset dominates mem_ready_in and start_in in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, addr_q 0.
- start_in at cycle 0 → first mem_req_out at cycle 1, mem_addr_out = start address.
- Each transfer takes 1 + wait cycles. With zero waits and n registers:
  - XFER occupies cycles 1..n.
  - W=1: WB at n+1, done_out at n+2.
  - W=0: done_out at n+1.
- n=0: done_out at cycle 1, busy_out high for that cycle only.
- The earliest new start_in is the cycle after done_out (IDLE).
- Strobes are Mealy on mem_ready_in during XFER: rf_we_out, reg_next_out. mem_req_out, mem_addr_out and wb_* are functions of registered state only.

## Test plan
- LDMIA, base 0x100, list 0x0005, W=1, ready always 1 → accesses 0x100 (r0) and 0x104 (r2), each with rf_we_out=1. wb_data_out=0x108 at cycle 3, done_out at cycle 4.
- STMDB, base 0x200, list 0x8003, W=1 → mem_we_out=1 at 0x1F4 (r0), 0x1F8 (r1), 0x1FC (r15). rf_we_out stays 0, wb_data_out=0x1F4.
- IB and DA, base 0x1000, list 0x00F0, W=0:
  - IB → addresses 0x1004..0x1010.
  - DA → addresses 0xFF4..0x1000.
  - Both: no wb_en_out, done_out at cycle 5.
- mem_ready_in low for 3 cycles on the 2nd transfer → mem_addr_out, rf_addr_out and mem_req_out held. Single rf_we_out/reg_next_out pulse per transfer; done_out delayed by exactly 3.
- Empty list → done_out at cycle 1, no mem_req_out, no wb_en_out.
- reset_in asserted mid-XFER → next cycle all outputs 0 and IDLE. Also: start_in pulsed while busy is ignored; base 0x0000_0004 with DB and n=2 wraps to start address 0xFFFF_FFFC.
